// File: rtl/stable_timer_pkg.sv
// ============================================================================
// Module   : stable_timer_pkg
// Purpose  : Shared CSR field positions and addresses for the stable timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stable_timer_pkg;

    // CSR_TCFG field positions
    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;

    // CSR_TICLR field positions
    localparam int TICLR_CLR        = 0;

    // ESTAT.IS bit driven by timer_irq
    localparam int IS_TIMER_BIT     = 11;

    // CSR addresses, decoded by the CSR unit
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

endpackage

`default_nettype wire

// File: rtl/stable_timer_tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Purpose  : Prescaler producing one tick every PRESCALE cycles while running.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_gen
    import stable_timer_pkg::*;
#(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int                 c_cw        = $clog2(PRESCALE);
    localparam logic [c_cw-1:0]    c_pcnt_last = c_cw'(PRESCALE - 1);

    logic [c_cw-1:0] r_pcnt;

    assign tick = run && (r_pcnt == c_pcnt_last);

    // restart (a TCFG write) takes priority over a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else if (restart) begin
            r_pcnt <= '0;
        end else if (tick) begin
            r_pcnt <= '0;
        end else if (run) begin
            r_pcnt <= r_pcnt + c_cw'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/stable_timer.sv
// ============================================================================
// Module   : stable_timer
// Purpose  : Constant-frequency countdown timer (TCFG/TVAL/TICLR, timer_irq).
// Revision : 1.0
// ============================================================================
`default_nettype none

module stable_timer
    import stable_timer_pkg::*;
#(
    parameter int TIMER_W  = 32,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    input  logic               ticlr_we,
    input  logic [31:0]        ticlr_wdata,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               timer_irq
);

    logic [TIMER_W-1:0] r_tcfg;
    logic [TIMER_W-1:0] r_tval;
    logic               r_running;
    logic               r_ti;

    logic               w_tick;
    logic               w_expire;
    logic               w_clear;
    logic [TIMER_W-1:0] w_reload;
    logic [TIMER_W-1:0] w_wr_reload;
    logic               w_unused;

    assign w_reload    = {r_tcfg[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
    assign w_wr_reload = {tcfg_wdata[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
    assign w_expire    = w_tick && (r_tval == '0);
    assign w_clear     = ticlr_we && ticlr_wdata[TICLR_CLR];
    assign w_unused    = ^ticlr_wdata[31:1];

    generate
        if (PRESCALE > 1) begin : g_prescale
            tick_gen #(
                .PRESCALE (PRESCALE)
            ) u_tick_gen (
                .clk     (clk),
                .rst_n   (rst_n),
                .run     (r_running),
                .restart (tcfg_we),
                .tick    (w_tick)
            );
        end else begin : g_no_prescale
            assign w_tick = r_running;
        end
    endgenerate

    // A TCFG write overrides the tick's effect on tval/running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcfg    <= '0;
            r_tval    <= '0;
            r_running <= 1'b0;
        end else if (tcfg_we) begin
            r_tcfg    <= tcfg_wdata;
            r_tval    <= w_wr_reload;
            r_running <= tcfg_wdata[TCFG_EN];
        end else if (w_tick) begin
            if (r_tval != '0) begin
                r_tval <= r_tval - TIMER_W'(1);
            end else if (r_tcfg[TCFG_PERIODIC]) begin
                r_tval <= w_reload;
            end else begin
                r_running <= 1'b0;
            end
        end
    end

    // Expiry beats a coincident clear so the event is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ti <= 1'b0;
        end else if (w_expire) begin
            r_ti <= 1'b1;
        end else if (w_clear) begin
            r_ti <= 1'b0;
        end
    end

    assign tcfg      = r_tcfg;
    assign tval      = r_tval;
    assign timer_irq = r_ti;

endmodule

`default_nettype wire

// File: tb/tb_stable_timer.sv
// ============================================================================
// Module   : tb_stable_timer
// Purpose  : Scoreboard bench for stable_timer at PRESCALE=1 and PRESCALE=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stable_timer;

    logic        clk;
    logic        rst_n;

    logic        tcfg_we1,  tcfg_we4;
    logic [31:0] tcfg_wdata1, tcfg_wdata4;
    logic        ticlr_we1, ticlr_we4;
    logic [31:0] ticlr_wdata1, ticlr_wdata4;
    logic [31:0] tcfg1, tval1, tcfg4, tval4;
    logic        irq1, irq4;

    int vectors;
    int miscompares;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    stable_timer #(.TIMER_W(32), .PRESCALE(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tcfg_we     (tcfg_we1),
        .tcfg_wdata  (tcfg_wdata1),
        .ticlr_we    (ticlr_we1),
        .ticlr_wdata (ticlr_wdata1),
        .tcfg        (tcfg1),
        .tval        (tval1),
        .timer_irq   (irq1)
    );

    stable_timer #(.TIMER_W(32), .PRESCALE(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tcfg_we     (tcfg_we4),
        .tcfg_wdata  (tcfg_wdata4),
        .ticlr_we    (ticlr_we4),
        .ticlr_wdata (ticlr_wdata4),
        .tcfg        (tcfg4),
        .tval        (tval4),
        .timer_irq   (irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            0:       return tcfg1;
            1:       return tval1;
            2:       return {31'd0, irq1};
            3:       return tcfg4;
            4:       return tval4;
            default: return {31'd0, irq4};
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        tcfg_we1     = 1'b0;  tcfg_wdata1  = '0;
        ticlr_we1    = 1'b0;  ticlr_wdata1 = '0;
        tcfg_we4     = 1'b0;  tcfg_wdata4  = '0;
        ticlr_we4    = 1'b0;  ticlr_wdata4 = '0;
        repeat (3) step();
        rst_n = 1'b1;

        // Idle after reset
        for (int k = 0; k < 20; k++) begin
            push("rst_tcfg", 0, 32'd0);
            push("rst_tval", 1, 32'd0);
            push("rst_irq",  2, 32'd0);
            drain();
            step();
        end
        push("rst_tcfg4", 3, 32'd0);
        push("rst_tval4", 4, 32'd0);
        push("rst_irq4",  5, 32'd0);
        drain();

        // One-shot R=16: expiry at N+17, then no re-fire
        tcfg_we1 = 1'b1; tcfg_wdata1 = 32'h0000_0011;
        step();
        tcfg_we1 = 1'b0;
        push("os_tcfg", 0, 32'h0000_0011);
        for (int k = 0; k <= 66; k++) begin
            push("os_tval", 1, (k <= 16) ? 32'(16 - k) : 32'd0);
            push("os_irq",  2, (k >= 17) ? 32'd1 : 32'd0);
            drain();
            step();
        end

        // Periodic R=8; TCFG write and TICLR together, then clears incl. one on an expiry edge
        tcfg_we1 = 1'b1; tcfg_wdata1 = 32'h0000_000B;
        ticlr_we1 = 1'b1; ticlr_wdata1 = 32'hFFFF_FFFF;
        step();
        tcfg_we1 = 1'b0;
        ticlr_we1 = 1'b0; ticlr_wdata1 = 32'h0000_0000;
        for (int k = 0; k <= 28; k++) begin
            logic [31:0] exp_irq;
            exp_irq = (k == 9 || k == 18 || k == 19 || k >= 27) ? 32'd1 : 32'd0;
            push("per_tval", 1, ((k % 9) == 0) ? 32'd8 : 32'(8 - (k % 9)));
            push("per_irq",  2, exp_irq);
            drain();
            if (k == 9 || k == 19 || k == 26) begin
                ticlr_we1 = 1'b1; ticlr_wdata1 = 32'h0000_0001;
            end else if (k == 3) begin
                ticlr_we1 = 1'b1; ticlr_wdata1 = 32'hFFFF_FFFE;
            end else begin
                ticlr_we1 = 1'b0; ticlr_wdata1 = 32'h0000_0000;
            end
            step();
        end
        ticlr_we1 = 1'b0;

        // Stop mid-count with InitVal=2: tval frozen at 8, pending TI kept
        tcfg_we1 = 1'b1; tcfg_wdata1 = 32'h0000_0008;
        step();
        tcfg_we1 = 1'b0;
        push("stop_tcfg", 0, 32'h0000_0008);
        for (int k = 0; k < 12; k++) begin
            push("stop_tval", 1, 32'd8);
            push("stop_irq",  2, 32'd1);
            drain();
            step();
        end

        // PRESCALE=4 one-shot R=4: steps at N+4..N+16, TI after N+20
        tcfg_we4 = 1'b1; tcfg_wdata4 = 32'h0000_0005;
        step();
        tcfg_we4 = 1'b0;
        for (int j = 0; j <= 30; j++) begin
            push("ps_tval", 4, (j <= 16) ? 32'(4 - j / 4) : 32'd0);
            push("ps_irq",  5, (j >= 20) ? 32'd1 : 32'd0);
            drain();
            step();
        end

        // Async reset mid-count on a periodic PRESCALE=4 timer
        ticlr_we4 = 1'b1; ticlr_wdata4 = 32'h0000_0001;
        tcfg_we4  = 1'b1; tcfg_wdata4  = 32'h0000_0007;
        step();
        tcfg_we4 = 1'b0; ticlr_we4 = 1'b0;
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        push("arst_tcfg1", 0, 32'd0);
        push("arst_tval1", 1, 32'd0);
        push("arst_irq1",  2, 32'd0);
        push("arst_tcfg4", 3, 32'd0);
        push("arst_tval4", 4, 32'd0);
        push("arst_irq4",  5, 32'd0);
        drain();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            push("post_tval4", 4, 32'd0);
            push("post_irq4",  5, 32'd0);
            drain();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
